multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multi-cycle control FSM for the basic MIPS datapath. It fetches one opcode per instruction over a request/acknowledge handshake and sequences FETCH, DECODE, EXEC, MEM and WB. It drives the datapath control lines only in the states where they apply, and counts retired instructions. Lost memory handshakes are caught by a timeout, and illegal opcodes by a sticky trap.

## Interface
- TIMEOUT, 16: max wait cycles for Imem_Ack/Dmem_Ack before trap; legal range 1..65535.
- CNT_W, 16: width of retired-instruction counter.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  level; leaves IDLE.
- Stop  in  1  level; finish current instruction, then return to IDLE.
- Trap_Clr  in  1  pulse; TRAP → IDLE.
- Imem_Req  out  1  instruction fetch request.
- Imem_Ack  in  1  fetch done; Opcode valid this cycle.
- Opcode  in  6  instruction opcode from instruction memory.
- Dmem_Ack  in  1  data access done.
- Pc_Write, Ir_Write  out  1  one-cycle strobes on fetch completion.
- Reg_Dst, Reg_Write, Alu_Src, Mem_Write, Mem_Read, Mem_To_Reg, Shamt_Sel  out  1  datapath controls.
- Alu_Control  out  4  ALU operation.
- Busy  out  1  state ≠ IDLE and ≠ TRAP.
- Illegal  out  1  sticky; high in TRAP.
- Instr_Count  out  CNT_W  retired instructions.

## Operation
- Opcodes:
  - ADD 000001, SUB 000010, INC 000011, DEC 000100, AND 000101, OR 000110, XOR 000111, NOT 001000, SLL 001001, SRL 001010.
  - LW 100010, SW 100100.
  - Any other value is illegal.
- ALU codes:
  - ADD 0101, SUB 0110, INC 0111, DEC 0100.
  - AND 0001, OR 0011, XOR 0010, NOT 0000.
  - SLL 1001, SRL 1010.
  - LW/SW 0101.
- Mem_To_Reg polarity: 1 selects ALU result; 0 selects memory data.
- Shamt_Sel = 1 only for SLL/SRL.
- Alu_Src = 1 and Reg_Dst = 0 for LW/SW; otherwise Alu_Src = 0 and Reg_Dst = 1.
- Opcode is latched into an internal IR on Imem_Ack. All later states decode from IR only.
- States and transitions:
  - IDLE: Start → FETCH.
  - FETCH: Imem_Req = 1. On Imem_Ack: latch IR, pulse Pc_Write/Ir_Write, → DECODE. Wait counter reaching TIMEOUT without ack → TRAP.
  - DECODE: illegal IR → TRAP; else → EXEC.
  - EXEC: R-type → WB; LW/SW → MEM.
  - MEM: Mem_Read (LW) or Mem_Write (SW) held until Dmem_Ack. Then LW → WB; SW → FETCH, or IDLE if Stop. Timeout → TRAP.
  - WB: Reg_Write = 1 for exactly one cycle, then → FETCH, or IDLE if Stop.
  - TRAP: Illegal = 1. Trap_Clr → IDLE; Start is ignored.
- Control hold rules:
  - Alu_Control, Alu_Src, Reg_Dst, Shamt_Sel and Mem_To_Reg are driven from IR during EXEC, MEM and WB, and are 0 elsewhere.
  - Reg_Write, Mem_Read and Mem_Write are 0 outside WB/MEM as stated above.
- Instr_Count increments on leaving WB, or leaving MEM for SW. It wraps from all-ones to 0.
- The wait counter clears on entering FETCH or MEM.

## Timing
- Reset (async, immediate): state IDLE, IR = 0, wait counter 0, Instr_Count = 0. Every output is 0.
- Control outputs are Moore outputs decoded from the registered state and IR.
- Latency with zero-wait acks (ack in the first cycle of FETCH/MEM):
  - R-type: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
- Each extra ack wait cycle adds one cycle.
- Simultaneous events:
  - Ack in the same cycle the counter hits TIMEOUT: ack wins.
  - Stop in the same cycle as Start in IDLE: Start wins; Stop then takes effect at the first instruction boundary.
  - Stop during FETCH, DECODE or EXEC: ignored until the WB/SW-MEM boundary.
  - Imem_Ack/Dmem_Ack outside FETCH/MEM: ignored.
  - Trap_Clr outside TRAP: ignored.
- Reset mid-operation: no retire is counted, and no partial write strobe is completed.

## Structure
- Shared package/include mips_defs: opcode constants, ALU codes, state encoding, TIMEOUT default.
- One sub-module, instr_decode: combinational IR → {legal, is_mem, is_load, Alu_Control, Alu_Src, Reg_Dst, Shamt_Sel, Mem_To_Reg}.
- The FSM, wait counter and retire counter live in multicycle_sequencer.

## Test plan
- Reset, Start, ADD (000001) with immediate acks:
  - FETCH→DECODE→EXEC→WB in 4 cycles.
  - Alu_Control = 0101; Reg_Write high exactly 1 cycle.
  - Instr_Count = 1.
- LW (100010) with Dmem_Ack delayed 3 cycles:
  - Mem_Read high 4 cycles; Alu_Src = 1; Mem_To_Reg = 0.
  - Total 8 cycles; Reg_Write in WB.
- Illegal opcode 111111: DECODE→TRAP, Illegal = 1, Busy = 0; Start ignored; Trap_Clr → IDLE.
- TIMEOUT = 4 with Imem_Ack never asserted: TRAP after 4 FETCH cycles. Ack on the 4th cycle instead proceeds to DECODE.
- Stop asserted during EXEC of SRL (001010): Shamt_Sel = 1, Alu_Control = 1010; completes WB, then IDLE; Instr_Count +1.
- rst_n low mid-MEM of SW: Mem_Write drops immediately; all outputs 0; Instr_Count = 0.
  - Preload Instr_Count near all-ones to check wrap to 0.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// Shared MIPS control definitions: opcodes, ALU codes, FSM states and
// the decoded-instruction record used by the multi-cycle sequencer.
package mips_defs;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int CNT_W_DEFAULT   = 16;
  localparam int WAIT_W          = 16;

  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_SUB = 6'b000010;
  localparam logic [5:0] OP_INC = 6'b000011;
  localparam logic [5:0] OP_DEC = 6'b000100;
  localparam logic [5:0] OP_AND = 6'b000101;
  localparam logic [5:0] OP_OR  = 6'b000110;
  localparam logic [5:0] OP_XOR = 6'b000111;
  localparam logic [5:0] OP_NOT = 6'b001000;
  localparam logic [5:0] OP_SLL = 6'b001001;
  localparam logic [5:0] OP_SRL = 6'b001010;
  localparam logic [5:0] OP_LW  = 6'b100010;
  localparam logic [5:0] OP_SW  = 6'b100100;

  localparam logic [3:0] ALU_ADD = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_INC = 4'b0111;
  localparam logic [3:0] ALU_DEC = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_NOT = 4'b0000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       is_mem;
    logic       is_load;
    logic [3:0] alu_control;
    logic       alu_src;
    logic       reg_dst;
    logic       shamt_sel;
    logic       mem_to_reg;
  } decode_t;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Control/handshake bundle between the sequencer (master) and the
// instruction/data memories plus datapath (slave).
interface multicycle_sequencer_if #(parameter int CNT_W = 16);

  logic             Start;
  logic             Stop;
  logic             Trap_Clr;
  logic             Imem_Req;
  logic             Imem_Ack;
  logic [5:0]       Opcode;
  logic             Dmem_Ack;
  logic             Pc_Write;
  logic             Ir_Write;
  logic             Reg_Dst;
  logic             Reg_Write;
  logic             Alu_Src;
  logic             Mem_Write;
  logic             Mem_Read;
  logic             Mem_To_Reg;
  logic             Shamt_Sel;
  logic [3:0]       Alu_Control;
  logic             Busy;
  logic             Illegal;
  logic [CNT_W-1:0] Instr_Count;

  modport master (
    input  Start, Stop, Trap_Clr, Imem_Ack, Opcode, Dmem_Ack,
    output Imem_Req, Pc_Write, Ir_Write, Reg_Dst, Reg_Write, Alu_Src,
           Mem_Write, Mem_Read, Mem_To_Reg, Shamt_Sel, Alu_Control,
           Busy, Illegal, Instr_Count
  );

  modport slave (
    output Start, Stop, Trap_Clr, Imem_Ack, Opcode, Dmem_Ack,
    input  Imem_Req, Pc_Write, Ir_Write, Reg_Dst, Reg_Write, Alu_Src,
           Mem_Write, Mem_Read, Mem_To_Reg, Shamt_Sel, Alu_Control,
           Busy, Illegal, Instr_Count
  );

endinterface

// File: rtl/multicycle_sequencer_instr_decode.sv
// Combinational opcode decoder: maps the latched IR to legality, memory
// class and the datapath control fields.
module instr_decode
  import mips_defs::*;
(
  input  logic [5:0] ir,
  output decode_t    dec
);

  always_comb begin
    dec = '0;
    dec.legal = 1'b1;
    case (ir)
      OP_ADD: dec.alu_control = ALU_ADD;
      OP_SUB: dec.alu_control = ALU_SUB;
      OP_INC: dec.alu_control = ALU_INC;
      OP_DEC: dec.alu_control = ALU_DEC;
      OP_AND: dec.alu_control = ALU_AND;
      OP_OR:  dec.alu_control = ALU_OR;
      OP_XOR: dec.alu_control = ALU_XOR;
      OP_NOT: dec.alu_control = ALU_NOT;
      OP_SLL: begin
        dec.alu_control = ALU_SLL;
        dec.shamt_sel   = 1'b1;
      end
      OP_SRL: begin
        dec.alu_control = ALU_SRL;
        dec.shamt_sel   = 1'b1;
      end
      OP_LW: begin
        dec.alu_control = ALU_ADD;
        dec.is_mem      = 1'b1;
        dec.is_load     = 1'b1;
      end
      OP_SW: begin
        dec.alu_control = ALU_ADD;
        dec.is_mem      = 1'b1;
      end
      default: dec.legal = 1'b0;
    endcase

    // Loads/stores use the immediate path and write back memory data
    if (dec.legal) begin
      dec.alu_src    = dec.is_mem;
      dec.reg_dst    = ~dec.is_mem;
      dec.mem_to_reg = ~dec.is_mem;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle MIPS control FSM: fetch/decode/exec/mem/wb sequencing with
// handshake timeouts, an illegal-opcode trap and a retired-instruction count.
module multicycle_sequencer
  import mips_defs::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_sequencer_if.master bus
);

  state_t           state, state_next;
  logic [5:0]       ir;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] instr_count;
  decode_t          dec;

  logic load_ir, clr_wait, inc_wait, retire;
  logic imem_req, pc_write, mem_read, mem_write, reg_write;
  logic timeout_hit, ctrl_phase;

  instr_decode u_decode (
    .ir  (ir),
    .dec (dec)
  );

  assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ir          <= '0;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      state <= state_next;
      if (load_ir)
        ir <= bus.Opcode;
      if (clr_wait)
        wait_cnt <= '0;
      else if (inc_wait)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (retire)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    load_ir    = 1'b0;
    inc_wait   = 1'b0;
    retire     = 1'b0;
    imem_req   = 1'b0;
    pc_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;

    case (state)
      ST_IDLE:
        if (bus.Start)
          state_next = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        // An ack arriving on the final allowed cycle still completes the fetch
        if (bus.Imem_Ack) begin
          load_ir    = 1'b1;
          pc_write   = 1'b1;
          state_next = ST_DECODE;
        end else if (timeout_hit) begin
          state_next = ST_TRAP;
        end else begin
          inc_wait = 1'b1;
        end
      end
      ST_DECODE:
        state_next = dec.legal ? ST_EXEC : ST_TRAP;
      ST_EXEC:
        state_next = dec.is_mem ? ST_MEM : ST_WB;
      ST_MEM: begin
        mem_read  = dec.is_load;
        mem_write = ~dec.is_load;
        if (bus.Dmem_Ack) begin
          if (dec.is_load) begin
            state_next = ST_WB;
          end else begin
            retire     = 1'b1;
            state_next = bus.Stop ? ST_IDLE : ST_FETCH;
          end
        end else if (timeout_hit) begin
          state_next = ST_TRAP;
        end else begin
          inc_wait = 1'b1;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = bus.Stop ? ST_IDLE : ST_FETCH;
      end
      ST_TRAP:
        if (bus.Trap_Clr)
          state_next = ST_IDLE;
      default:
        state_next = ST_IDLE;
    endcase

    clr_wait = ((state_next == ST_FETCH) && (state != ST_FETCH)) ||
               ((state_next == ST_MEM)   && (state != ST_MEM));
  end

  assign ctrl_phase = (state == ST_EXEC) || (state == ST_MEM) || (state == ST_WB);

  assign bus.Imem_Req    = imem_req;
  assign bus.Pc_Write    = pc_write;
  assign bus.Ir_Write    = pc_write;
  assign bus.Reg_Write   = reg_write;
  assign bus.Mem_Read    = mem_read;
  assign bus.Mem_Write   = mem_write;
  assign bus.Alu_Control = ctrl_phase ? dec.alu_control : 4'b0000;
  assign bus.Alu_Src     = ctrl_phase & dec.alu_src;
  assign bus.Reg_Dst     = ctrl_phase & dec.reg_dst;
  assign bus.Shamt_Sel   = ctrl_phase & dec.shamt_sel;
  assign bus.Mem_To_Reg  = ctrl_phase & dec.mem_to_reg;
  assign bus.Busy        = (state != ST_IDLE) && (state != ST_TRAP);
  assign bus.Illegal     = (state == ST_TRAP);
  assign bus.Instr_Count = instr_count;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: table-driven instruction
// runs with a control-signal scoreboard, plus trap/timeout/stop/reset cases.
module tb_multicycle_sequencer;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 3;

  typedef struct packed {
    logic [3:0] alu;
    logic       alu_src;
    logic       reg_dst;
    logic       shamt;
    logic       m2r;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    int         iw;
    int         dw;
    int         cycles;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [TB_CNT_W-1:0] exp_count = '0;
  exp_t sb[$];
  vec_t vecs[14];

  multicycle_sequencer_if #(.CNT_W(TB_CNT_W)) bus ();

  multicycle_sequencer #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference control values written straight from the opcode table
  function automatic void model(input logic [5:0] op, output logic legal, output exp_t e);
    legal = 1'b1;
    e = '0;
    case (op)
      6'b000001: e.alu = 4'b0101;
      6'b000010: e.alu = 4'b0110;
      6'b000011: e.alu = 4'b0111;
      6'b000100: e.alu = 4'b0100;
      6'b000101: e.alu = 4'b0001;
      6'b000110: e.alu = 4'b0011;
      6'b000111: e.alu = 4'b0010;
      6'b001000: e.alu = 4'b0000;
      6'b001001: begin e.alu = 4'b1001; e.shamt = 1'b1; end
      6'b001010: begin e.alu = 4'b1010; e.shamt = 1'b1; end
      6'b100010, 6'b100100: begin e.alu = 4'b0101; e.alu_src = 1'b1; end
      default: legal = 1'b0;
    endcase
    if (legal && !e.alu_src) begin
      e.reg_dst = 1'b1;
      e.m2r     = 1'b1;
    end
  endfunction

  function automatic logic [31:0] allOuts();
    return 32'({bus.Imem_Req, bus.Pc_Write, bus.Ir_Write, bus.Reg_Dst, bus.Reg_Write,
                bus.Alu_Src, bus.Mem_Write, bus.Mem_Read, bus.Mem_To_Reg, bus.Shamt_Sel,
                bus.Alu_Control, bus.Busy, bus.Illegal, bus.Instr_Count});
  endfunction

  // Scoreboard monitor: compare datapath controls at each instruction's completion
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      sb.delete();
    end else if (bus.Reg_Write || (bus.Mem_Write && bus.Dmem_Ack)) begin
      if (sb.size() == 0) begin
        checkOutput("sb_empty_at_completion", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sb_ctrl", 32'({bus.Alu_Control, bus.Alu_Src, bus.Reg_Dst, bus.Shamt_Sel, bus.Mem_To_Reg}),
                    32'(e));
      end
    end
  end

  task automatic startPulse();
    @(negedge clk);
    bus.Start = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
  endtask

  // Runs one instruction from its first FETCH cycle to its retire boundary
  task automatic applyStimulus(input string name, input logic [5:0] op, input int iw, input int dw,
                               input logic stop_in_exec, input int exp_cycles);
    int   cycles = 0;
    int   fw = 0, mw = 0, rw_cnt = 0, pc_cnt = 0, mr_cnt = 0, ack_cyc = -10;
    logic done = 1'b0;
    logic legal;
    exp_t e;
    model(op, legal, e);
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      bus.Imem_Ack = 1'b0;
      bus.Dmem_Ack = 1'b0;
      if (bus.Imem_Req) begin
        if (fw == iw) begin
          bus.Imem_Ack = 1'b1;
          bus.Opcode   = op;
          ack_cyc      = cycles;
          if (legal) sb.push_back(e);
        end else begin
          fw++;
          bus.Opcode = 6'($urandom);
        end
      end else if (bus.Mem_Read || bus.Mem_Write) begin
        if (mw == dw) bus.Dmem_Ack = 1'b1;
        else mw++;
      end
      if (stop_in_exec && cycles == ack_cyc + 2) bus.Stop = 1'b1;
      #1;
      if (bus.Pc_Write && bus.Ir_Write) pc_cnt++;
      if (bus.Reg_Write) rw_cnt++;
      if (bus.Mem_Read) mr_cnt++;
      if (bus.Reg_Write || (bus.Mem_Write && bus.Dmem_Ack) || bus.Illegal) done = 1'b1;
    end
    checkOutput({name, "_done"}, 32'(done), 32'd1);
    checkOutput({name, "_cycles"}, 32'(cycles), 32'(exp_cycles));
    checkOutput({name, "_pc_write"}, 32'(pc_cnt), 32'd1);
    checkOutput({name, "_reg_write"}, 32'(rw_cnt), (legal && op != 6'b100100) ? 32'd1 : 32'd0);
    checkOutput({name, "_mem_read"}, 32'(mr_cnt), (op == 6'b100010) ? 32'(dw + 1) : 32'd0);
    @(posedge clk);
    #1;
    bus.Imem_Ack = 1'b0;
    bus.Dmem_Ack = 1'b0;
    if (legal) exp_count = exp_count + 1'b1;
    checkOutput({name, "_count"}, 32'(bus.Instr_Count), 32'(exp_count));
  endtask

  initial begin
    vecs[0]  = '{6'b000001, 0, 0, 4};
    vecs[1]  = '{6'b000010, 2, 0, 6};
    vecs[2]  = '{6'b000011, 0, 0, 4};
    vecs[3]  = '{6'b000100, 1, 0, 5};
    vecs[4]  = '{6'b000101, 0, 0, 4};
    vecs[5]  = '{6'b000110, 0, 0, 4};
    vecs[6]  = '{6'b000111, 3, 0, 7};
    vecs[7]  = '{6'b001000, 0, 0, 4};
    vecs[8]  = '{6'b001001, 0, 0, 4};
    vecs[9]  = '{6'b001010, 0, 0, 4};
    vecs[10] = '{6'b100010, 0, 3, 8};
    vecs[11] = '{6'b100100, 0, 0, 4};
    vecs[12] = '{6'b100100, 1, 2, 7};
    vecs[13] = '{6'b100010, 1, 0, 6};

    bus.Start = 1'b0; bus.Stop = 1'b0; bus.Trap_Clr = 1'b0;
    bus.Imem_Ack = 1'b0; bus.Dmem_Ack = 1'b0; bus.Opcode = 6'b000000;

    #12;
    checkOutput("reset_outputs", allOuts(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_outputs", allOuts(), 32'd0);

    startPulse();
    checkOutput("start_busy", 32'({bus.Busy, bus.Imem_Req}), 32'b11);

    for (int i = 0; i < 14; i++)
      applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].iw, vecs[i].dw, 1'b0, vecs[i].cycles);

    applyStimulus("srl_stop", 6'b001010, 0, 0, 1'b1, 4);
    checkOutput("srl_stop_idle", 32'({bus.Busy, bus.Imem_Req}), 32'b00);
    bus.Stop = 1'b0;

    @(negedge clk);
    bus.Start = 1'b1;
    bus.Stop  = 1'b1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    checkOutput("start_beats_stop", 32'(bus.Busy), 32'd1);
    applyStimulus("add_stop", 6'b000001, 0, 0, 1'b0, 4);
    checkOutput("add_stop_idle", 32'(bus.Busy), 32'd0);
    bus.Stop = 1'b0;

    startPulse();
    applyStimulus("illegal", 6'b111111, 0, 0, 1'b0, 3);
    checkOutput("trap_flags", 32'({bus.Illegal, bus.Busy}), 32'b10);
    bus.Start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("trap_ignores_start", 32'({bus.Illegal, bus.Imem_Req}), 32'b10);
    bus.Start = 1'b0;
    @(negedge clk);
    bus.Trap_Clr = 1'b1;
    @(posedge clk);
    #1;
    bus.Trap_Clr = 1'b0;
    checkOutput("trap_clr_idle", 32'({bus.Illegal, bus.Busy}), 32'b00);

    startPulse();
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("timeout_wait%0d", i), 32'({bus.Imem_Req, bus.Illegal}), 32'b10);
    end
    @(posedge clk);
    #1;
    checkOutput("timeout_trap", 32'({bus.Illegal, bus.Busy}), 32'b10);
    @(negedge clk);
    bus.Trap_Clr = 1'b1;
    @(posedge clk);
    #1;
    bus.Trap_Clr = 1'b0;

    startPulse();
    applyStimulus("ack_at_timeout", 6'b000001, TB_TIMEOUT - 1, 0, 1'b0, 4 + TB_TIMEOUT - 1);

    begin
      int guard = 0;
      while (!bus.Mem_Write && guard < 20) begin
        @(negedge clk);
        bus.Opcode   = 6'b100100;
        bus.Imem_Ack = bus.Imem_Req;
        #1;
        guard++;
      end
      bus.Imem_Ack = 1'b0;
    end
    checkOutput("sw_in_mem", 32'(bus.Mem_Write), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_mem", allOuts(), 32'd0);
    exp_count = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_reset_idle", allOuts(), 32'd0);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
